// File: rtl/data_mem.sv
// Single-port word memory behind a req/ack handshake with a fixed number of wait states.
// Byte-enabled writes; out-of-range accesses are acked with err set and leave storage untouched.
module data_mem #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 256,
    parameter int WAIT   = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req,
    input  logic                we,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] be,
    output logic                busy,
    output logic                ack,
    output logic [DATA_W-1:0]   rdata,
    output logic                err
);
    localparam int BE_W  = DATA_W / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT_ST, RESP} state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [BE_W-1:0]     be_q;
    logic                err_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic                acc_we;
    logic [ADDR_W-1:0]   acc_addr;
    logic [DATA_W-1:0]   acc_wdata;
    logic [BE_W-1:0]     acc_be;
    logic                in_range;
    logic [IDX_W-1:0]    idx;
    logic [DATA_W-1:0]   old_word;
    logic [DATA_W-1:0]   merged;
    logic                enter_resp;

    // With WAIT=0 the commit happens on the accepting edge, so the live inputs are used there.
    always_comb begin
        if (state_q == IDLE) begin
            acc_we    = we;
            acc_addr  = addr;
            acc_wdata = wdata;
            acc_be    = be;
        end else begin
            acc_we    = we_q;
            acc_addr  = addr_q;
            acc_wdata = wdata_q;
            acc_be    = be_q;
        end
    end

    assign in_range = ({1'b0, acc_addr} < DEPTH_L);
    assign idx      = acc_addr[IDX_W-1:0];
    assign old_word = mem[idx];

    always_comb begin
        merged = old_word;
        for (int i = 0; i < BE_W; i++) begin
            if (acc_be[i]) merged[8*i +: 8] = acc_wdata[8*i +: 8];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    cnt_d   = 4'(WAIT);
                    state_d = (WAIT > 0) ? WAIT_ST : RESP;
                end
            end
            WAIT_ST: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign enter_resp = rst_n && (state_d == RESP) && (state_q != RESP);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (enter_resp) begin
                err_q <= !in_range;
                if (!in_range)  rdata_q <= '0;
                else if (acc_we) rdata_q <= merged;
                else            rdata_q <= old_word;
            end
        end
    end

    // Request fields are data, not control: captured on accept, never reset.
    always_ff @(posedge clk) begin
        if (state_q == IDLE && req) begin
            we_q    <= we;
            addr_q  <= addr;
            wdata_q <= wdata;
            be_q    <= be;
        end
    end

    always_ff @(posedge clk) begin
        if (enter_resp && acc_we && in_range) begin
            for (int i = 0; i < BE_W; i++) begin
                if (acc_be[i]) mem[idx][8*i +: 8] <= acc_wdata[8*i +: 8];
            end
        end
    end

    assign busy  = (state_q != IDLE);
    assign ack   = (state_q == RESP);
    assign err   = ack & err_q;
    assign rdata = rdata_q;

endmodule

// File: tb/tb_data_mem.sv
// Directed bench for data_mem: a WAIT=2 instance for the main behaviour and a WAIT=0 instance.
module tb_data_mem;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req, we;
    logic [15:0] addr, wdata;
    logic [1:0]  be;
    logic        busy, ack, err;
    logic [15:0] rdata;

    logic        req1, we1;
    logic [15:0] addr1, wdata1;
    logic [1:0]  be1;
    logic        busy1, ack1, err1;
    logic [15:0] rdata1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_mem #(.DATA_W(16), .ADDR_W(16), .DEPTH(256), .WAIT(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata), .be(be),
        .busy(busy), .ack(ack), .rdata(rdata), .err(err)
    );

    data_mem #(.DATA_W(16), .ADDR_W(16), .DEPTH(256), .WAIT(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .req(req1), .we(we1), .addr(addr1), .wdata(wdata1), .be(be1),
        .busy(busy1), .ack(ack1), .rdata(rdata1), .err(err1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One access on the WAIT=2 instance; inputs are scrambled right after capture.
    task automatic access(input logic w, input logic [15:0] a, input logic [15:0] d,
                          input logic [1:0] b, output logic [15:0] rd, output logic e,
                          output int lat);
        @(negedge clk);
        we = w; addr = a; wdata = d; be = b; req = 1'b1;
        @(posedge clk);
        #1;
        req = 1'b0; we = ~w; addr = a ^ 16'h0001; wdata = ~d; be = ~b;
        lat = 0; rd = 'x; e = 1'bx;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (ack) begin
                lat = i; rd = rdata; e = err;
                break;
            end
        end
    endtask

    initial begin
        logic [15:0] rd;
        logic        e;
        int          lat;
        int          n_ack, n_idle, n_bad;

        rst_n = 1'b0; req = 0; we = 0; addr = 0; wdata = 0; be = 0;
        req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0; be1 = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_ack", ack, 0);
        check("rst_err", err, 0);
        check("rst_rdata", rdata, 0);
        rst_n = 1'b1;

        access(1, 16'h0010, 16'hBEEF, 2'b11, rd, e, lat);
        check("wr_latency", lat, 3);
        check("wr_err", e, 0);
        check("wr_raw_rdata", rd, 16'hBEEF);
        access(0, 16'h0010, 16'h0000, 2'b00, rd, e, lat);
        check("rd_latency", lat, 3);
        check("rd_rdata", rd, 16'hBEEF);
        check("rd_err", e, 0);

        access(1, 16'h0020, 16'h1234, 2'b11, rd, e, lat);
        access(1, 16'h0020, 16'hAB00, 2'b10, rd, e, lat);
        check("be_wr_rdata", rd, 16'hAB34);
        access(0, 16'h0020, 16'h0000, 2'b01, rd, e, lat);
        check("be_rd_rdata", rd, 16'hAB34);
        access(1, 16'h0020, 16'hFFFF, 2'b00, rd, e, lat);
        check("be0_ack_latency", lat, 3);
        check("be0_rdata", rd, 16'hAB34);

        access(1, 16'h0000, 16'h5555, 2'b11, rd, e, lat);
        access(1, 16'h0100, 16'hFFFF, 2'b11, rd, e, lat);
        check("oor_err", e, 1);
        check("oor_rdata", rd, 16'h0000);
        @(negedge clk);
        check("post_ack_low", ack, 0);
        check("post_err_low", err, 0);
        check("post_rdata_hold", rdata, 16'h0000);
        access(0, 16'h0000, 16'h0000, 2'b11, rd, e, lat);
        check("nowrap_rdata", rd, 16'h5555);
        check("nowrap_err", e, 0);

        // req held high: accepts on edges 0,4,8,.. acks in the cycle after edges 2,6,..
        @(negedge clk);
        check("b2b_idle_before", busy, 0);
        we = 0; addr = 16'h0010; be = 2'b11; req = 1'b1;
        n_ack = 0; n_idle = 0; n_bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (ack) n_ack++;
            if (!busy) n_idle++;
            if (ack !== (i % 4 == 2)) n_bad++;
            if (busy !== (i % 4 != 3)) n_bad++;
            if (ack && rdata !== 16'hBEEF) n_bad++;
        end
        req = 1'b0;
        check("b2b_acks", n_ack, 5);
        check("b2b_idle_cycles", n_idle, 5);
        check("b2b_pattern", n_bad, 0);

        access(1, 16'h0030, 16'h1111, 2'b11, rd, e, lat);
        @(negedge clk);
        we = 1; addr = 16'h0030; wdata = 16'h0BAD; be = 2'b11; req = 1'b1;
        @(posedge clk);
        #1;
        req = 1'b0;
        @(negedge clk);
        check("mid_in_wait", busy, 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mid_busy", busy, 0);
        check("mid_ack", ack, 0);
        check("mid_rdata", rdata, 0);
        n_ack = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (ack) n_ack++;
        end
        check("mid_no_ack", n_ack, 0);
        access(0, 16'h0030, 16'h0000, 2'b11, rd, e, lat);
        check("mid_rd_rdata", rd, 16'h1111);

        @(negedge clk);
        rst_n = 1'b0; req = 1'b1; we = 1; addr = 16'h0010; wdata = 16'h0000; be = 2'b11;
        @(negedge clk);
        check("rst_prio_busy", busy, 0);
        rst_n = 1'b1; req = 1'b0;
        access(0, 16'h0010, 16'h0000, 2'b11, rd, e, lat);
        check("rst_prio_data", rd, 16'hBEEF);

        // WAIT=0 instance
        @(negedge clk);
        req1 = 1; we1 = 1; addr1 = 16'h0005; wdata1 = 16'h4242; be1 = 2'b11;
        @(posedge clk);
        #1;
        req1 = 0;
        @(negedge clk);
        check("w0_wr_ack", ack1, 1);
        check("w0_wr_rdata", rdata1, 16'h4242);
        @(negedge clk);
        req1 = 1; we1 = 0; addr1 = 16'h0005;
        @(posedge clk);
        #1;
        req1 = 0;
        @(negedge clk);
        check("w0_rd_ack", ack1, 1);
        check("w0_rd_rdata", rdata1, 16'h4242);
        check("w0_rd_err", err1, 0);
        @(negedge clk);
        req1 = 1;
        n_ack = 0; n_bad = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (ack1) n_ack++;
            if (ack1 !== (i % 2 == 0)) n_bad++;
        end
        req1 = 0;
        check("w0_b2b_acks", n_ack, 4);
        check("w0_b2b_pattern", n_bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/data_mem.md
DATA_MEM -- requirements
Module: data_mem

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, data word width in bits; a multiple of 8.
REQ-002 The block SHALL have parameter ADDR_W, default 16, address width in bits.
REQ-003 The block SHALL have parameter DEPTH, default 256, number of words; DEPTH <= 2**ADDR_W.
REQ-004 The block SHALL have parameter WAIT, default 1, number of wait-state cycles per access; range 0..15.
REQ-005 The block SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst_n  input  1  reset; synchronous, active-low.
REQ-007 The block SHALL have port req  input  1  access request; sampled only in IDLE.
REQ-008 The block SHALL have port we  input  1  1 = write, 0 = read; captured with req.
REQ-009 The block SHALL have port addr  input  ADDR_W  word address; captured with req.
REQ-010 The block SHALL have port wdata  input  DATA_W  write data; captured with req.
REQ-011 The block SHALL have port be  input  DATA_W/8  byte enables; bit i gates wdata[8i+7:8i]; captured with req.
REQ-012 The block SHALL have port busy  output  1  high whenever the state is not IDLE.
REQ-013 The block SHALL have port ack  output  1  one-cycle completion strobe.
REQ-014 The block SHALL have port rdata  output  DATA_W  registered read data; valid while ack=1.
REQ-015 The block SHALL have port err  output  1  out-of-range flag; valid while ack=1.

Function
REQ-016 The block SHALL implement the FSM states IDLE, WAIT_ST and RESP.
REQ-017 In IDLE with req=1, the block SHALL capture we, addr, wdata and be at the clock edge and load the wait counter with WAIT.
REQ-018 On that edge, the block SHALL enter WAIT_ST if WAIT>0, otherwise RESP directly.
REQ-019 In WAIT_ST, the counter SHALL decrement each cycle; on the edge where the counter is 1 the state SHALL become RESP.
REQ-020 The write commit and the rdata register update SHALL occur on the edge that enters RESP.
REQ-021 RESP SHALL last exactly one cycle with ack=1, then return to IDLE unconditionally.
REQ-022 Latency SHALL be WAIT+1 cycles from the accepting edge to the ack cycle; the minimum request spacing is WAIT+2 cycles.
REQ-023 req in WAIT_ST or RESP SHALL be ignored; inputs changing after capture SHALL have no effect.
REQ-024 On a write, only bytes with be[i]=1 SHALL be updated; the other bytes SHALL retain their prior value; be=0 SHALL be a legal no-op write that is still acked.
REQ-025 On a write, rdata SHALL be loaded with the word value after the commit (read-after-write on the same word).
REQ-026 On a read, be SHALL be ignored and rdata SHALL be loaded with the full stored word.
REQ-027 If the captured addr >= DEPTH, the block SHALL perform no write, load rdata with 0 and assert err=1 alongside ack; otherwise err=0.
REQ-028 Outside the RESP cycle, ack and err SHALL be 0 and rdata SHALL hold its last value.
REQ-029 The storage SHALL be DEPTH words of DATA_W bits; addressing SHALL NOT wrap (upper addr bits are not dropped).

Reset
REQ-030 When rst_n=0 at an edge, the block SHALL set state to IDLE and busy, ack, err and rdata to 0, and clear the wait counter.
REQ-031 Memory contents SHALL NOT be reset.
REQ-032 Reset during WAIT_ST or on the edge that would enter RESP SHALL abandon the access, with no write commit and no ack.
REQ-033 rst_n=0 SHALL take priority over req at the same edge.
REQ-034 The first request SHALL be accepted on the first edge with rst_n=1 and req=1.

Verification (DATA_W=16, DEPTH=256, WAIT=2 unless stated)
REQ-035 Basic write/read: write 0xBEEF to addr 0x0010 with be=2'b11 -> ack 3 cycles after the accept edge with err=0; a subsequent read of 0x0010 -> rdata=0xBEEF, err=0.
REQ-036 Byte enables: write 0x1234 to 0x0020 with be=11, then 0xAB00 with be=10, then read -> rdata=0xAB34.
REQ-037 Out of range: write 0xFFFF to 0x0100 -> ack with err=1 and rdata=0; a read of 0x0000 (preloaded 0x5555) -> 0x5555, err=0.
REQ-038 Back-to-back: req held at 1 for 20 cycles -> exactly one ack every 4 cycles; busy low only in the accept cycles.
REQ-039 Reset mid-access: 0x0030 holds 0x1111; issue a write of 0x0BAD and pull rst_n low for one cycle in WAIT_ST -> no ack, busy=0; a subsequent read returns 0x1111.
REQ-040 WAIT=0 instance: a read is acked on the cycle after the accept edge; requests are accepted every 2 cycles.
